// File: rtl/matmul_job_scheduler_if.sv
// Host-side stream, operand-memory write port and control/result signals of the matmul job
// scheduler, bundled so the scheduler and its host share one declaration.
interface matmul_job_scheduler_if;
    logic        cfg_reuse;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        enable;
    logic        stat_weights;
    logic        load_weights;
    logic [63:0] acc_in;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        busy;
    logic        done;

    modport master (
        output cfg_reuse, in_valid, in_data, acc_in, out_ready,
        input  in_ready, wr_en, wr_addr, wr_data, enable, stat_weights, load_weights,
        input  out_valid, out_data, busy, done
    );

    modport slave (
        input  cfg_reuse, in_valid, in_data, acc_in, out_ready,
        output in_ready, wr_en, wr_addr, wr_data, enable, stat_weights, load_weights,
        output out_valid, out_data, busy, done
    );
endinterface

// File: rtl/matmul_job_scheduler.sv
// Job sequencer for the 2x2 systolic matmul: loads operands from a byte stream, runs the
// engine for a fixed window, then streams the four 16-bit results back as bytes.
module matmul_job_scheduler #(
    parameter int unsigned COMPUTE_CYCLES = 6,
    parameter int unsigned RES_W          = 16
) (
    input logic             clk,
    input logic             rst,
    matmul_job_scheduler_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StLoad, StCompute, StDrain} state_e;

    localparam logic [3:0] LastCnt = 4'(COMPUTE_CYCLES - 1);

    state_e               state;
    logic [2:0]           ptr;
    logic [2:0]           idx;
    logic [3:0]           cnt;
    logic                 wvalid;
    logic [4*RES_W-1:0]   res;
    logic                 reuse_hit;
    logic [2:0]           start_ptr;
    logic                 accept;

    // Reuse is honoured only when a previous job left valid weights in memory.
    assign reuse_hit = bus.cfg_reuse & wvalid;
    assign start_ptr = reuse_hit ? 3'd4 : 3'd0;
    assign accept    = bus.in_valid & bus.in_ready;

    assign bus.wr_en    = accept;
    assign bus.wr_addr  = (state == StIdle) ? start_ptr : ptr;
    assign bus.wr_data  = bus.in_data;
    assign bus.out_data = res[{idx, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= StIdle;
            ptr              <= 3'd0;
            idx              <= 3'd0;
            cnt              <= 4'd0;
            wvalid           <= 1'b0;
            res              <= '0;
            bus.in_ready     <= 1'b1;
            bus.enable       <= 1'b0;
            bus.out_valid    <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.stat_weights <= 1'b0;
            bus.load_weights <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                StIdle: begin
                    if (accept) begin
                        bus.stat_weights <= bus.cfg_reuse;
                        bus.load_weights <= ~reuse_hit;
                        if (!bus.cfg_reuse) wvalid <= 1'b0;
                        ptr      <= start_ptr + 3'd1;
                        bus.busy <= 1'b1;
                        state    <= StLoad;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        if (ptr == 3'd7) begin
                            if (bus.load_weights) wvalid <= 1'b1;
                            ptr          <= 3'd0;
                            cnt          <= 4'd0;
                            bus.in_ready <= 1'b0;
                            bus.enable   <= 1'b1;
                            state        <= StCompute;
                        end else begin
                            ptr <= ptr + 3'd1;
                        end
                    end
                end
                StCompute: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LastCnt) begin
                        res           <= bus.acc_in;
                        idx           <= 3'd0;
                        bus.enable    <= 1'b0;
                        bus.out_valid <= 1'b1;
                        state         <= StDrain;
                    end
                end
                StDrain: begin
                    if (bus.out_ready) begin
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            bus.out_valid <= 1'b0;
                            bus.in_ready  <= 1'b1;
                            bus.busy      <= 1'b0;
                            bus.done      <= 1'b1;
                            state         <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
